// File: rtl/firmware_config_sequencer.sv
// Queues firmware-register write commands, pauses tracing at a frame boundary and
// serialises each command onto the configId/configData bus as a 3-byte frame plus gap.
module firmware_config_sequencer #(
  parameter int MAX_CHAINS   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int EOF_TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing_req,
  input  logic                          stream_valid,
  input  logic                          stream_eof,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_block_id,
  input  logic [2:0]                    cmd_field,
  input  logic [$clog2(MAX_CHAINS)-1:0] cmd_chain,
  input  logic [7:0]                    cmd_value,
  output logic                          tracing,
  output logic [7:0]                    configId,
  output logic [7:0]                    configData,
  output logic                          busy,
  output logic                          cmd_error,
  output logic [2:0]                    dbg_state
);

  localparam int CW = $clog2(MAX_CHAINS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(EOF_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_EOF, DRAIN, HDR, CHAIN, DATA, GAP, RESUME
  } state_t;

  typedef struct packed {
    logic [7:0]    block_id;
    logic [2:0]    field;
    logic [CW-1:0] chain;
    logic [7:0]    value;
  } entry_t;

  // Handshake: a command transfers on any rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered queue occupancy, never on cmd_valid.
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          accept;
  logic          cmd_ok;
  logic          push;
  logic          pop;
  state_t        state;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dcnt;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ok    = (cmd_block_id != 8'd0) && (cmd_field <= 3'd4) && (int'(cmd_chain) < MAX_CHAINS);
  assign push      = accept && cmd_ok;
  assign pop       = (state == DATA);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd_block_id, cmd_field, cmd_chain, cmd_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_error <= 1'b0;
    end else begin
      cmd_error <= accept && !cmd_ok;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tracing    <= 1'b0;
      configId   <= '0;
      configData <= '0;
      tcnt       <= '0;
      dcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // tracing only follows the host while nothing is pending
          if (empty) tracing <= tracing_req;
          else if (tracing) begin
            state <= WAIT_EOF;
            tcnt  <= '0;
          end else state <= HDR;
        end
        WAIT_EOF: begin
          if ((stream_valid && stream_eof) || (tcnt == TW'(EOF_TIMEOUT - 1))) begin
            state   <= DRAIN;
            tracing <= 1'b0;
            dcnt    <= '0;
          end else tcnt <= tcnt + 1'b1;
        end
        DRAIN: begin
          if (dcnt == DW'(DRAIN_CYCLES - 1)) state <= HDR;
          else dcnt <= dcnt + 1'b1;
        end
        HDR: begin
          configId   <= head.block_id;
          configData <= {5'b0, head.field};
          state      <= CHAIN;
        end
        CHAIN: begin
          configData <= 8'(head.chain);
          state      <= DATA;
        end
        DATA: begin
          configData <= head.value;
          state      <= GAP;
        end
        GAP: begin
          configId   <= '0;
          configData <= '0;
          state      <= empty ? RESUME : HDR;
        end
        RESUME: begin
          tracing <= tracing_req;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_firmware_config_sequencer.sv
// Bench for firmware_config_sequencer: command table, hand-written timing sequences,
// and a bus scoreboard fed from the commands as they are handed over.
module tb_firmware_config_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tracing_req;
  logic       stream_valid;
  logic       stream_eof;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_block_id;
  logic [2:0] cmd_field;
  logic [1:0] cmd_chain;
  logic [7:0] cmd_value;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       cmd_error;
  logic [2:0] dbg_state;

  firmware_config_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tracing_req(tracing_req),
    .stream_valid(stream_valid), .stream_eof(stream_eof),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_block_id(cmd_block_id), .cmd_field(cmd_field),
    .cmd_chain(cmd_chain), .cmd_value(cmd_value),
    .tracing(tracing), .configId(configId), .configData(configData),
    .busy(busy), .cmd_error(cmd_error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int bus_beats = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  typedef struct {
    logic [7:0] id;
    logic [2:0] f;
    logic [1:0] ch;
    logic [7:0] v;
    logic       err;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: presents one command, holds it until the handshake edge
  task automatic send(input logic [7:0] id, input logic [2:0] f, input logic [1:0] ch,
                      input logic [7:0] v);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_block_id = id; cmd_field = f; cmd_chain = ch; cmd_value = v;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    if (id != 8'd0 && f <= 3'd4) begin
      exp_q.push_back({id, 5'd0, f});
      exp_q.push_back({id, 6'd0, ch});
      exp_q.push_back({id, v});
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  // scoreboard: every nonzero bus beat must be the next expected one, with tracing off
  always @(negedge clk) begin
    if (rst_n && configId != 8'd0) begin
      bus_beats++;
      check("bus_tracing_off", {31'd0, tracing}, 32'd0);
      if (exp_q.size() == 0) check("bus_unexpected", {24'd0, configId}, 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("bus_beat", {16'd0, configId, configData}, {16'd0, mon_exp});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, te, th, beats0, n;
    logic ok;

    tbl[0] = '{8'd3,   3'd1, 2'd2, 8'h05, 1'b0};
    tbl[1] = '{8'd0,   3'd1, 2'd1, 8'h01, 1'b1};
    tbl[2] = '{8'd5,   3'd5, 2'd0, 8'h01, 1'b1};
    tbl[3] = '{8'hff,  3'd4, 2'd3, 8'haa, 1'b0};
    tbl[4] = '{8'd1,   3'd0, 2'd0, 8'h00, 1'b0};
    tbl[5] = '{8'd7,   3'd7, 2'd1, 8'h09, 1'b1};
    tbl[6] = '{8'd200, 3'd2, 2'd1, 8'h33, 1'b0};
    tbl[7] = '{8'd0,   3'd6, 2'd3, 8'hff, 1'b1};

    rst_n = 1'b0; tracing_req = 1'b0; stream_valid = 1'b0; stream_eof = 1'b0;
    cmd_valid = 1'b0; cmd_block_id = '0; cmd_field = '0; cmd_chain = '0; cmd_value = '0;
    #22;
    check("rst_tracing", {31'd0, tracing}, 32'd0);
    check("rst_configId", {24'd0, configId}, 32'd0);
    check("rst_configData", {24'd0, configData}, 32'd0);
    check("rst_cmd_error", {31'd0, cmd_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // T1 frame timing with tracing off
    send(8'd3, 3'd1, 2'd2, 8'h05);
    check("t1_bus_idle_e0", {24'd0, configId}, 32'd0);
    tick();
    check("t1_bus_idle_hdr", {24'd0, configId}, 32'd0);
    tick();
    check("t1_hdr", {16'd0, configId, configData}, {16'd0, 8'd3, 8'd1});
    tick();
    check("t1_chain", {16'd0, configId, configData}, {16'd0, 8'd3, 8'd2});
    tick();
    check("t1_data", {16'd0, configId, configData}, {16'd0, 8'd3, 8'd5});
    tick();
    check("t1_gap", {16'd0, configId, configData}, 32'd0);
    check("t1_busy_resume", {31'd0, busy}, 32'd1);
    tick();
    check("t1_busy_low", {31'd0, busy}, 32'd0);

    // table: valid commands are framed, invalid ones only pulse cmd_error (T5)
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].id, tbl[i].f, tbl[i].ch, tbl[i].v);
      check("tbl_cmd_error", {31'd0, cmd_error}, {31'd0, tbl[i].err});
      if (tbl[i].err) begin
        check("tbl_err_busy", {31'd0, busy}, 32'd0);
        tick();
        check("tbl_err_pulse_end", {31'd0, cmd_error}, 32'd0);
        check("tbl_err_busy_next", {31'd0, busy}, 32'd0);
      end
      wait_idle(100);
      check("tbl_tracing", {31'd0, tracing}, 32'd0);
    end

    // T2 eof-triggered drain
    tracing_req = 1'b1;
    tick(); tick();
    check("t2_tracing_on", {31'd0, tracing}, 32'd1);
    send(8'd9, 3'd3, 2'd1, 8'h77);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stream_valid = 1'($urandom_range(0, 1));
      tick();
      if (tracing !== 1'b1) ok = 1'b0;
    end
    check("t2_tracing_held", {31'd0, ok}, 32'd1);
    stream_valid = 1'b1; stream_eof = 1'b1;
    tick();
    te = cyc;
    stream_valid = 1'b0; stream_eof = 1'b0;
    check("t2_tracing_drop", {31'd0, tracing}, 32'd0);
    n = 0;
    while (configId == 8'd0 && n < 50) begin
      tick();
      n++;
    end
    check("t2_drain_to_frame", cyc - te, 32'd5);
    wait_idle(100);
    check("t2_tracing_restored", {31'd0, tracing}, 32'd1);

    // T3 eof timeout
    send(8'd12, 3'd0, 2'd3, 8'h5a);
    n = 0;
    while (tracing && n < 1200) begin
      tick();
      n++;
    end
    check("t3_timeout_cycles", n, 32'd1025);
    wait_idle(100);
    check("t3_tracing_restored", {31'd0, tracing}, 32'd1);

    // T4a nine back-to-back commands with tracing off form one batch
    tracing_req = 1'b0;
    tick(); tick();
    check("t4_tracing_off", {31'd0, tracing}, 32'd0);
    beats0 = bus_beats;
    t0 = 0;
    for (int i = 0; i < 9; i++) begin
      send(8'($urandom_range(1, 255)), 3'($urandom_range(0, 4)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if (i == 0) t0 = cyc;
    end
    wait_idle(200);
    check("t4_batch_cycles", cyc - t0, 32'd38);
    check("t4_bus_beats", bus_beats - beats0, 32'd27);

    // T4b queue fills while waiting for eof; a pop re-opens cmd_ready one cycle later
    tracing_req = 1'b1;
    tick(); tick();
    for (int i = 0; i < 8; i++)
      send(8'(8'd20 + 8'(i)), 3'(i % 5), 2'(i % 4), 8'($urandom_range(0, 255)));
    check("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
    check("t4_full_busy", {31'd0, busy}, 32'd1);
    te = 0; th = 0;
    fork
      begin
        send(8'd99, 3'd4, 2'd2, 8'hc3);
        th = cyc;
      end
      begin
        tick(); tick(); tick();
        stream_valid = 1'b1; stream_eof = 1'b1;
        tick();
        te = cyc;
        stream_valid = 1'b0; stream_eof = 1'b0;
      end
    join
    check("t4_ready_after_pop", th - te, 32'd8);
    wait_idle(200);
    check("t4_tracing_restored", {31'd0, tracing}, 32'd1);

    // T6 reset during CHAIN
    tracing_req = 1'b0;
    tick(); tick();
    send(8'd4, 3'd2, 2'd1, 8'h11);
    send(8'd6, 3'd0, 2'd3, 8'h22);
    tick();
    check("t6_in_frame", {24'd0, configId}, 32'd4);
    tracing_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_configId", {24'd0, configId}, 32'd0);
    check("t6_rst_configData", {24'd0, configData}, 32'd0);
    check("t6_rst_tracing", {31'd0, tracing}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    tick();
    tracing_req = 1'b0;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || configId !== 8'd0) ok = 1'b0;
    end
    check("t6_queue_empty_after_reset", {31'd0, ok}, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
